ram_dp_clr: RTL and testbench

- Parametrised successor to the single-port CPU data RAM.
- Port A: CPU read/write with byte enables. Port B: read-only, for the video/renderer side.
- Built-in clear sequencer fills memory with CLEAR_VALUE after reset or on command.
- Sits on the CPU bus (16-bit address) alongside ROM and I/O; port B feeds the display logic.

---
 rtl/ram_pkg.sv | 35 +++
 rtl/ram_clear_seq.sv | 62 ++++++
 rtl/ram_dp_clr.sv | 144 ++++++++++++++
 tb/tb_ram_dp_clr.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// ram_pkg: shared types and helpers for the dual-port clearable RAM.
//   state_t     - clear sequencer state
//   RDW_OLD/NEW - port-B read-during-write selection
//   byte_merge  - byte-enable merge of an old and new word (up to MERGE_MAX_W bits)
package ram_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    localparam int unsigned RDW_OLD = 0;
    localparam int unsigned RDW_NEW = 1;

    // Widest word the merge helper supports; callers zero-extend and truncate.
    localparam int unsigned MERGE_MAX_W  = 128;
    localparam int unsigned MERGE_MAX_BE = MERGE_MAX_W / 8;

    // Replace each byte of old_word whose enable bit is set with the byte of new_word.
    function automatic logic [MERGE_MAX_W-1:0] byte_merge(
        input logic [MERGE_MAX_W-1:0]  old_word,
        input logic [MERGE_MAX_W-1:0]  new_word,
        input logic [MERGE_MAX_BE-1:0] be
    );
        logic [MERGE_MAX_W-1:0] res;
        res = old_word;
        for (int unsigned i = 0; i < MERGE_MAX_BE; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/ram_clear_seq.sv
// ram_clear_seq: sequencer that walks every memory address once, writing the
// clear value, either after reset or on a CLEAR command received while idle.
//   clk, rst   - clock, synchronous active-high reset
//   clear      - start request, honoured only in IDLE
//   busy       - clear in progress
//   clear_done - one-cycle pulse the cycle after the last clear write
//   clr_we     - memory write strobe for the clear value
//   clr_addr   - memory address being cleared
module ram_clear_seq
    import ram_pkg::*;
#(
    parameter int unsigned ADDR_BITS      = 12,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    output logic                 busy,
    output logic                 clear_done,
    output logic                 clr_we,
    output logic [ADDR_BITS-1:0] clr_addr
);

    localparam logic [ADDR_BITS-1:0] LAST_ADDR = '1;

    state_t               state;
    logic [ADDR_BITS-1:0] count;

    // State, address counter and done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
            count      <= '0;
            clear_done <= 1'b0;
        end else begin
            clear_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (clear) begin
                        state <= ST_CLEAR;
                        count <= '0;
                    end
                end
                ST_CLEAR: begin
                    // Counter wraps to 0 after the last address, ready for the next clear.
                    count <= count + 1'b1;
                    if (count == LAST_ADDR) begin
                        state      <= ST_IDLE;
                        clear_done <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy     = (state == ST_CLEAR);
    // Reset holds the state in CLEAR but must never write the array.
    assign clr_we   = busy && !rst;
    assign clr_addr = count;

endmodule

// File: rtl/ram_dp_clr.sv
// ram_dp_clr: dual-port RAM with built-in clear sequencer.
// Port A is the CPU read/write port with byte enables (write-first data out);
// port B is read-only for the display side. Both have 1-cycle latency and are
// stalled (READY=0) while a clear is running.
//   Clock, Reset                       - clock, synchronous active-high reset
//   A_CS/A_RW/A_ADDR/A_BE/A_DATA_IN    - port-A request
//   A_READY, A_DATA_OUT, A_VALID       - port-A handshake and response
//   B_CS/B_ADDR                        - port-B read request
//   B_READY, B_DATA_OUT, B_VALID       - port-B handshake and response
//   CLEAR, BUSY, CLEAR_DONE            - clear command and status
//   A_ERR                              - out-of-range port-A access (RAM_OOR_CHECK_EN only)
// Optional feature macro: RAM_OOR_CHECK_EN. When defined, port-A addresses with
// nonzero bits above ADDR_BITS are rejected instead of aliasing.
module ram_dp_clr
    import ram_pkg::*;
#(
    parameter int unsigned       WIDTH          = 16,
    parameter int unsigned       ADDR_BITS      = 12,
    parameter logic [WIDTH-1:0]  CLEAR_VALUE    = '0,
    parameter bit                CLEAR_ON_RESET = 1'b1,
    parameter int unsigned       B_RDW_NEW      = RDW_OLD
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 A_CS,
    input  logic                 A_RW,
    input  logic [15:0]          A_ADDR,
    input  logic [WIDTH/8-1:0]   A_BE,
    input  logic [WIDTH-1:0]     A_DATA_IN,
    output logic                 A_READY,
    output logic [WIDTH-1:0]     A_DATA_OUT,
    output logic                 A_VALID,
`ifdef RAM_OOR_CHECK_EN
    output logic                 A_ERR,
`endif
    input  logic                 B_CS,
    input  logic [ADDR_BITS-1:0] B_ADDR,
    output logic                 B_READY,
    output logic [WIDTH-1:0]     B_DATA_OUT,
    output logic                 B_VALID,
    input  logic                 CLEAR,
    output logic                 BUSY,
    output logic                 CLEAR_DONE
);

    localparam int unsigned DEPTH = 2 ** ADDR_BITS;

    logic [WIDTH-1:0]     mem [DEPTH];

    logic                 busy;
    logic                 clr_we;
    logic [ADDR_BITS-1:0] clr_addr;

    logic [ADDR_BITS-1:0] a_idx;
    logic                 a_acc;
    logic                 b_acc;
    logic                 a_oor;
    logic                 a_we;
    logic                 b_hit;
    logic [WIDTH-1:0]     a_old;
    logic [WIDTH-1:0]     a_merged;

    ram_clear_seq #(
        .ADDR_BITS      (ADDR_BITS),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_clear_seq (
        .clk        (Clock),
        .rst        (Reset),
        .clear      (CLEAR),
        .busy       (busy),
        .clear_done (CLEAR_DONE),
        .clr_we     (clr_we),
        .clr_addr   (clr_addr)
    );

    assign BUSY    = busy;
    assign A_READY = !busy;
    assign B_READY = !busy;

    assign a_idx = A_ADDR[ADDR_BITS-1:0];
    assign a_acc = A_CS && !busy;
    assign b_acc = B_CS && !busy;

`ifdef RAM_OOR_CHECK_EN
    assign a_oor = (32'(A_ADDR) >> ADDR_BITS) != 32'd0;
`else
    // Upper address bits alias onto the array.
    logic unused_addr_hi;
    assign unused_addr_hi = ^(32'(A_ADDR) >> ADDR_BITS);
    assign a_oor          = 1'b0;
`endif

    assign a_old    = mem[a_idx];
    assign a_merged = WIDTH'(byte_merge(MERGE_MAX_W'(a_old), MERGE_MAX_W'(A_DATA_IN),
                                        MERGE_MAX_BE'(A_BE)));
    assign a_we     = a_acc && A_RW && !a_oor && !Reset;
    assign b_hit    = a_we && (a_idx == B_ADDR);

    // Array write: clear sequencer and port A are mutually exclusive via busy.
    always_ff @(posedge Clock) begin
        if (clr_we) begin
            mem[clr_addr] <= CLEAR_VALUE;
        end else if (a_we) begin
            mem[a_idx] <= a_merged;
        end
    end

    // Registered port responses; data holds when no request is accepted.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            A_DATA_OUT <= '0;
            A_VALID    <= 1'b0;
            B_DATA_OUT <= '0;
            B_VALID    <= 1'b0;
`ifdef RAM_OOR_CHECK_EN
            A_ERR      <= 1'b0;
`endif
        end else begin
            A_VALID <= a_acc;
            B_VALID <= b_acc;
`ifdef RAM_OOR_CHECK_EN
            A_ERR   <= a_acc && a_oor;
`endif
            if (a_acc) begin
                if (a_oor) begin
                    A_DATA_OUT <= '0;
                end else if (A_RW) begin
                    A_DATA_OUT <= a_merged;
                end else begin
                    A_DATA_OUT <= a_old;
                end
            end
            if (b_acc) begin
                // Same-address collision: optionally forward the merged write word.
                if (b_hit && (B_RDW_NEW == RDW_NEW)) begin
                    B_DATA_OUT <= a_merged;
                end else begin
                    B_DATA_OUT <= mem[B_ADDR];
                end
            end
        end
    end

endmodule

// File: tb/tb_ram_dp_clr.sv
// tb_ram_dp_clr: directed bench for ram_dp_clr (ADDR_BITS=4, CLEAR_VALUE=A5A5).
// Two instances share all inputs; they differ only in port-B read-during-write mode.
// Honours RAM_OOR_CHECK_EN for the out-of-range / aliasing sequence.
module tb_ram_dp_clr;

    localparam logic [15:0] CV = 16'hA5A5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, a_cs, a_rw, b_cs, clear;
    logic [15:0] a_addr, a_din;
    logic [1:0]  a_be;
    logic [3:0]  b_addr;

    logic        a_ready, a_valid, b_ready, b_valid, busy, clear_done;
    logic [15:0] a_dout, b_dout;
    logic        n_a_ready, n_a_valid, n_b_ready, n_b_valid, n_busy, n_clear_done;
    logic [15:0] n_a_dout, n_b_dout;
`ifdef RAM_OOR_CHECK_EN
    logic        a_err, n_a_err;
`endif

    ram_dp_clr #(
        .WIDTH(16), .ADDR_BITS(4), .CLEAR_VALUE(CV), .CLEAR_ON_RESET(1'b1), .B_RDW_NEW(0)
    ) u_old (
        .Clock(clk), .Reset(rst),
        .A_CS(a_cs), .A_RW(a_rw), .A_ADDR(a_addr), .A_BE(a_be), .A_DATA_IN(a_din),
        .A_READY(a_ready), .A_DATA_OUT(a_dout), .A_VALID(a_valid),
`ifdef RAM_OOR_CHECK_EN
        .A_ERR(a_err),
`endif
        .B_CS(b_cs), .B_ADDR(b_addr), .B_READY(b_ready), .B_DATA_OUT(b_dout), .B_VALID(b_valid),
        .CLEAR(clear), .BUSY(busy), .CLEAR_DONE(clear_done)
    );

    ram_dp_clr #(
        .WIDTH(16), .ADDR_BITS(4), .CLEAR_VALUE(CV), .CLEAR_ON_RESET(1'b1), .B_RDW_NEW(1)
    ) u_new (
        .Clock(clk), .Reset(rst),
        .A_CS(a_cs), .A_RW(a_rw), .A_ADDR(a_addr), .A_BE(a_be), .A_DATA_IN(a_din),
        .A_READY(n_a_ready), .A_DATA_OUT(n_a_dout), .A_VALID(n_a_valid),
`ifdef RAM_OOR_CHECK_EN
        .A_ERR(n_a_err),
`endif
        .B_CS(b_cs), .B_ADDR(b_addr), .B_READY(n_b_ready), .B_DATA_OUT(n_b_dout), .B_VALID(n_b_valid),
        .CLEAR(clear), .BUSY(n_busy), .CLEAR_DONE(n_clear_done)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Samples busy / clear_done over a fixed window that covers a whole clear.
    task automatic watch_clear(output int nbusy, output int ndone);
        nbusy = 0;
        ndone = 0;
        for (int i = 0; i < 24; i++) begin
            if (busy) nbusy++;
            if (clear_done) ndone++;
            step();
        end
    endtask

    typedef struct {
        logic        a_cs;
        logic        a_rw;
        logic [15:0] a_addr;
        logic [1:0]  a_be;
        logic [15:0] a_din;
        logic        b_cs;
        logic [3:0]  b_addr;
        logic        ea_valid;
        logic [15:0] ea_data;
        logic        eb_valid;
        logic [15:0] eb_old;
        logic [15:0] eb_new;
    } vec_t;

    vec_t vecs [11];

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int nb, nd, nready, dones;
        logic bad_valid, bad_ready, bad_hold;
        logic [15:0] exp_hold;

        //                 a_cs  a_rw  a_addr    a_be   a_din     b_cs  b_addr ea_v  ea_data   eb_v  eb_old    eb_new
        vecs[0]  = '{1'b1, 1'b1, 16'h0003, 2'b11, 16'h1234, 1'b1, 4'h3, 1'b1, 16'h1234, 1'b1, 16'hA5A5, 16'h1234};
        vecs[1]  = '{1'b1, 1'b1, 16'h0003, 2'b01, 16'hFFFF, 1'b0, 4'h3, 1'b1, 16'h12FF, 1'b0, 16'hA5A5, 16'h1234};
        vecs[2]  = '{1'b1, 1'b0, 16'h0003, 2'b00, 16'h0000, 1'b1, 4'h3, 1'b1, 16'h12FF, 1'b1, 16'h12FF, 16'h12FF};
        vecs[3]  = '{1'b1, 1'b1, 16'h0005, 2'b11, 16'h0000, 1'b1, 4'h4, 1'b1, 16'h0000, 1'b1, 16'hA5A5, 16'hA5A5};
        vecs[4]  = '{1'b1, 1'b1, 16'h0005, 2'b11, 16'hBEEF, 1'b1, 4'h5, 1'b1, 16'hBEEF, 1'b1, 16'h0000, 16'hBEEF};
        vecs[5]  = '{1'b1, 1'b1, 16'h0005, 2'b00, 16'h1111, 1'b1, 4'h5, 1'b1, 16'hBEEF, 1'b1, 16'hBEEF, 16'hBEEF};
        vecs[6]  = '{1'b0, 1'b0, 16'h0000, 2'b00, 16'h0000, 1'b0, 4'h0, 1'b0, 16'hBEEF, 1'b0, 16'hBEEF, 16'hBEEF};
        vecs[7]  = '{1'b1, 1'b1, 16'h0006, 2'b10, 16'h7700, 1'b1, 4'h6, 1'b1, 16'h77A5, 1'b1, 16'hA5A5, 16'h77A5};
        vecs[8]  = '{1'b1, 1'b0, 16'h0006, 2'b00, 16'h0000, 1'b0, 4'h6, 1'b1, 16'h77A5, 1'b0, 16'hA5A5, 16'h77A5};
        vecs[9]  = '{1'b0, 1'b0, 16'h0000, 2'b00, 16'h0000, 1'b1, 4'h7, 1'b0, 16'h77A5, 1'b1, 16'hA5A5, 16'hA5A5};
        vecs[10] = '{1'b1, 1'b0, 16'h0005, 2'b11, 16'h0000, 1'b1, 4'h6, 1'b1, 16'hBEEF, 1'b1, 16'h77A5, 16'h77A5};

        rst = 1'b1; a_cs = 1'b0; a_rw = 1'b0; a_addr = '0; a_be = '0; a_din = '0;
        b_cs = 1'b0; b_addr = '0; clear = 1'b0;
        repeat (3) step();

        // Reset state
        chk("rst_a_valid", 32'(a_valid), 32'd0);
        chk("rst_b_valid", 32'(b_valid), 32'd0);
        chk("rst_a_data", 32'(a_dout), 32'd0);
        chk("rst_b_data", 32'(b_dout), 32'd0);
        chk("rst_clear_done", 32'(clear_done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);

        // Clear after reset: 16 busy cycles, one done pulse
        rst = 1'b0;
        watch_clear(nb, nd);
        chk("reset_clear_busy_cycles", 32'(nb), 32'd16);
        chk("reset_clear_done_count", 32'(nd), 32'd1);

        // Every address reads the clear value on both ports
        for (int i = 0; i < 16; i++) begin
            a_cs = 1'b1; a_rw = 1'b0; a_addr = 16'(i); b_cs = 1'b1; b_addr = 4'(15 - i);
            step();
            chk("clear_read_a", {15'd0, a_valid, a_dout}, {15'd0, 1'b1, CV});
            chk("clear_read_b", {15'd0, b_valid, b_dout}, {15'd0, 1'b1, CV});
        end

        // Table-driven single-cycle vectors
        for (int v = 0; v < 11; v++) begin
            a_cs = vecs[v].a_cs; a_rw = vecs[v].a_rw; a_addr = vecs[v].a_addr;
            a_be = vecs[v].a_be; a_din = vecs[v].a_din;
            b_cs = vecs[v].b_cs; b_addr = vecs[v].b_addr;
            step();
            chk("vec_a_valid", 32'(a_valid), 32'(vecs[v].ea_valid));
            chk("vec_a_data", 32'(a_dout), 32'(vecs[v].ea_data));
            chk("vec_b_valid", 32'(b_valid), 32'(vecs[v].eb_valid));
            chk("vec_b_data_rdw_old", 32'(b_dout), 32'(vecs[v].eb_old));
            chk("vec_b_data_rdw_new", 32'(n_b_dout), 32'(vecs[v].eb_new));
        end
        a_cs = 1'b0; b_cs = 1'b0;

        // Upper address bits: rejected with the check enabled, aliased otherwise
        a_cs = 1'b1; a_rw = 1'b1; a_addr = 16'h0013; a_be = 2'b11; a_din = 16'h4321;
        step();
        chk("oor_a_valid", 32'(a_valid), 32'd1);
`ifdef RAM_OOR_CHECK_EN
        chk("oor_a_err", 32'(a_err), 32'd1);
        chk("oor_a_data", 32'(a_dout), 32'd0);
        exp_hold = 16'h12FF;
`else
        chk("alias_a_data", 32'(a_dout), 32'h4321);
        exp_hold = 16'h4321;
`endif
        a_rw = 1'b0; a_addr = 16'h0003;
        step();
        chk("oor_readback_addr3", 32'(a_dout), 32'(exp_hold));
`ifdef RAM_OOR_CHECK_EN
        chk("oor_err_clears", 32'(a_err), 32'd0);
`endif
        a_cs = 1'b0;
        step();

        // CLEAR command with requests held through BUSY; a CLEAR mid-clear is ignored
        clear = 1'b1;
        step();
        clear = 1'b0;
        a_cs = 1'b1; a_rw = 1'b0; a_addr = 16'h0003; b_cs = 1'b1; b_addr = 4'h6;
        nready = 0; dones = 0; bad_valid = 1'b0; bad_ready = 1'b0; bad_hold = 1'b0;
        for (int i = 0; i < 40 && !a_ready; i++) begin
            nready++;
            if (a_valid || b_valid) bad_valid = 1'b1;
            if (b_ready) bad_ready = 1'b1;
            if (a_dout !== exp_hold) bad_hold = 1'b1;
            if (clear_done) dones++;
            clear = (i == 5);
            step();
        end
        clear = 1'b0;
        chk("cmd_clear_not_ready_cycles", 32'(nready), 32'd16);
        chk("cmd_clear_no_valid_while_busy", 32'(bad_valid), 32'd0);
        chk("cmd_clear_b_not_ready", 32'(bad_ready), 32'd0);
        chk("cmd_clear_data_held", 32'(bad_hold), 32'd0);
        chk("cmd_clear_early_done", 32'(dones), 32'd0);
        chk("cmd_clear_done_pulse", 32'(clear_done), 32'd1);
        chk("cmd_clear_b_ready", 32'(b_ready), 32'd1);
        chk("cmd_clear_no_valid_yet", 32'(a_valid), 32'd0);
        step();
        chk("post_clear_a_valid", 32'(a_valid), 32'd1);
        chk("post_clear_a_data", 32'(a_dout), 32'(CV));
        chk("post_clear_b_data", 32'(b_dout), 32'(CV));
        chk("post_clear_done_low", 32'(clear_done), 32'd0);
        a_cs = 1'b0; b_cs = 1'b0;
        step();
        chk("idle_a_valid", 32'(a_valid), 32'd0);

        // Reset at clear counter 7 restarts a full clear
        a_cs = 1'b1; a_rw = 1'b1; a_addr = 16'h000A; a_be = 2'b11; a_din = 16'h1357;
        step();
        chk("pre_reset_write", 32'(a_dout), 32'h1357);
        a_cs = 1'b0;
        clear = 1'b1;
        step();
        clear = 1'b0;
        dones = 0;
        for (int i = 0; i < 7; i++) begin
            if (clear_done) dones++;
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midclr_rst_busy", 32'(busy), 32'd1);
        watch_clear(nb, nd);
        chk("midclr_busy_cycles", 32'(nb), 32'd16);
        chk("midclr_done_count", 32'(nd + dones), 32'd1);
        a_cs = 1'b1; a_rw = 1'b0; a_addr = 16'h000A;
        step();
        chk("midclr_read_addr10", 32'(a_dout), 32'(CV));
        a_addr = 16'h0007;
        step();
        chk("midclr_read_addr7", 32'(a_dout), 32'(CV));
        a_cs = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
